// File: rtl/voice_slot_sched.sv
// voice_slot_sched: round-robin time-slot scheduler for the shared voice datapath.
// Presents one voice per clock (slot, slot_div), stages note-change requests
// through a valid/ready handshake and commits them only at frame boundaries,
// optionally held until a beat has been seen.
// Optional build macro VOICE_SCHED_MUTE_EN adds a per-voice mute input that
// forces slot_div to 0 and clears active_mask for muted voices.
module voice_slot_sched #(
  parameter int NUM_VOICES = 4,
  parameter int VOICE_W    = $clog2(NUM_VOICES),
  parameter int DIV_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef VOICE_SCHED_MUTE_EN
  input  logic [NUM_VOICES-1:0] mute,
`endif
  input  logic                  en,
  input  logic                  beat_tick,
  input  logic                  note_valid,
  output logic                  note_ready,
  input  logic [VOICE_W-1:0]    note_voice,
  input  logic [DIV_W-1:0]      note_div,
  input  logic                  note_on_beat,
  output logic [VOICE_W-1:0]    slot,
  output logic [DIV_W-1:0]      slot_div,
  output logic                  slot_first,
  output logic [NUM_VOICES-1:0] active_mask,
  output logic [NUM_VOICES-1:0] pending_mask
);

  logic [VOICE_W-1:0]    cnt_q;
  logic                  beat_seen_q;
  logic [DIV_W-1:0]      div_q  [NUM_VOICES];
  logic [DIV_W-1:0]      sdiv_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] sbeat_q;
  logic [NUM_VOICES-1:0] pend_q;
  logic [NUM_VOICES-1:0] mute_v;

  logic fb;
  logic bs;
  logic accept;

`ifdef VOICE_SCHED_MUTE_EN
  assign mute_v = mute;
`else
  assign mute_v = '0;
`endif

  // Frame boundary, same-cycle beat view and handshake acceptance.
  always_comb begin
    fb         = 1'b1;
    if (en) fb = (cnt_q == VOICE_W'(NUM_VOICES - 1));
    bs         = beat_seen_q | beat_tick;
    note_ready = !pend_q[note_voice];
    accept     = note_valid && note_ready;
  end

  // Active voices: committed divider non-zero and not muted.
  always_comb begin
    active_mask = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      active_mask[v] = (div_q[v] != '0) && !mute_v[v];
    end
  end

  assign pending_mask = pend_q;

  // Slot counter; held at 0 while disabled so re-enable starts a fresh frame.
  always_ff @(posedge clk) begin
    if (!rst_n)  cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + VOICE_W'(1);
    else         cnt_q <= '0;
  end

  // Registered slot outputs, one cycle behind the counter.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      slot       <= '0;
      slot_div   <= '0;
      slot_first <= 1'b0;
    end else begin
      slot       <= cnt_q;
      slot_div   <= mute_v[cnt_q] ? '0 : div_q[cnt_q];
      slot_first <= (cnt_q == '0);
    end
  end

  // Sticky beat flag; any frame boundary that sees a beat consumes it.
  always_ff @(posedge clk) begin
    if (!rst_n)  beat_seen_q <= 1'b0;
    else if (fb) beat_seen_q <= 1'b0;
    else         beat_seen_q <= bs;
  end

  // Per-voice staging and commit. Accept and commit never coincide for one
  // voice because ready is low while that voice has a note pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        div_q[v]  <= '0;
        sdiv_q[v] <= '0;
      end
      sbeat_q <= '0;
      pend_q  <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (fb && pend_q[v] && (!sbeat_q[v] || bs)) begin
          div_q[v]  <= sdiv_q[v];
          pend_q[v] <= 1'b0;
        end else if (accept && (note_voice == VOICE_W'(v))) begin
          sdiv_q[v]  <= note_div;
          sbeat_q[v] <= note_on_beat;
          pend_q[v]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_slot_sched.sv
// Directed bench for voice_slot_sched with NUM_VOICES=4, DIV_W=12.
module tb_voice_slot_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        beat_tick;
  logic        note_valid;
  logic        note_ready;
  logic [1:0]  note_voice;
  logic [11:0] note_div;
  logic        note_on_beat;
  logic [1:0]  slot;
  logic [11:0] slot_div;
  logic        slot_first;
  logic [3:0]  active_mask;
  logic [3:0]  pending_mask;
`ifdef VOICE_SCHED_MUTE_EN
  logic [3:0]  mute = 4'b0000;
`endif

  int n_vec = 0;
  int n_bad = 0;

  voice_slot_sched #(.NUM_VOICES(4), .DIV_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef VOICE_SCHED_MUTE_EN
    .mute         (mute),
`endif
    .en           (en),
    .beat_tick    (beat_tick),
    .note_valid   (note_valid),
    .note_ready   (note_ready),
    .note_voice   (note_voice),
    .note_div     (note_div),
    .note_on_beat (note_on_beat),
    .slot         (slot),
    .slot_div     (slot_div),
    .slot_first   (slot_first),
    .active_mask  (active_mask),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance until the given slot is presented; at most 8 cycles.
  task automatic run_to_slot(input logic [1:0] s);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (slot !== s && n < 8);
    chk("run_to_slot", {30'd0, slot}, {30'd0, s});
  endtask

  task automatic req(input logic [1:0] v, input logic [11:0] d, input logic ob);
    note_valid   = 1'b1;
    note_voice   = v;
    note_div     = d;
    note_on_beat = ob;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; beat_tick = 1'b0;
    note_valid = 1'b0; note_voice = '0; note_div = '0; note_on_beat = 1'b0;
    tick(); tick();
    chk("rst_slot", slot, 0);
    chk("rst_slot_div", slot_div, 0);
    chk("rst_slot_first", slot_first, 0);
    chk("rst_active", active_mask, 0);
    chk("rst_pending", pending_mask, 0);
    chk("rst_ready", note_ready, 1);

    // Free-running rotation, everything silent.
    rst_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rot_slot", slot, i % 4);
      chk("rot_div", slot_div, 0);
      chk("rot_first", slot_first, (i % 4 == 0) ? 1 : 0);
    end

    // Immediate note: voice 2 = 956, accepted at counter 1.
    tick();                                  // slot 0, counter 1
    req(2'd2, 12'd956, 1'b0);
    chk("v2_ready", note_ready, 1);
    tick(); note_valid = 1'b0;               // slot 1
    chk("v2_pend", pending_mask, 4'b0100);
    tick();                                  // slot 2, not yet committed
    chk("v2_midframe", slot_div, 0);
    chk("v2_pend2", pending_mask, 4'b0100);
    tick();                                  // slot 3, FB edge committed
    chk("v2_pend_clr", pending_mask, 0);
    chk("v2_active", active_mask, 4'b0100);
    run_to_slot(2);
    chk("v2_div", slot_div, 956);
    run_to_slot(2);
    chk("v2_div_again", slot_div, 956);

    // Beat-aligned note: voice 1 = 1277, accepted on an FB cycle.
    req(2'd1, 12'd1277, 1'b1);
    tick(); note_valid = 1'b0;               // slot 3
    chk("v1_pend", pending_mask, 4'b0010);
    for (int f = 0; f < 3; f++) begin
      run_to_slot(1);
      chk("v1_wait_div", slot_div, 0);
    end
    chk("v1_still_pend", pending_mask, 4'b0010);
    beat_tick = 1'b1;                        // counter 2
    tick(); beat_tick = 1'b0;                // slot 2
    chk("v1_pend_after_tick", pending_mask, 4'b0010);
    tick();                                  // slot 3, FB consumed beat
    chk("v1_committed", pending_mask, 0);
    run_to_slot(1);
    chk("v1_div", slot_div, 1277);
    chk("v1_active", active_mask, 4'b0110);

    // Back-to-back requests to voice 1.
    req(2'd1, 12'd1136, 1'b0);               // counter 2
    tick();                                  // slot 2, staged
    req(2'd1, 12'd851, 1'b0);
    chk("v1_busy_ready", note_ready, 0);
    tick();                                  // slot 3, FB commits 1136
    chk("v1_free_ready", note_ready, 1);
    chk("v1_pend_gone", pending_mask, 0);
    tick(); note_valid = 1'b0;               // slot 0, 851 accepted
    chk("v1_second_pend", pending_mask, 4'b0010);
    tick();                                  // slot 1
    chk("v1_first_val", slot_div, 1136);
    run_to_slot(3);
    chk("v1_second_commit", pending_mask, 0);
    run_to_slot(1);
    chk("v1_second_val", slot_div, 851);

    // Beat consumed earlier: new beat-aligned notes must wait.
    req(2'd0, 12'd1519, 1'b1);               // counter 2
    tick(); note_valid = 1'b0;               // slot 2
    tick();                                  // slot 3, FB without beat
    chk("v0_waits", pending_mask, 4'b0001);
    req(2'd3, 12'd1914, 1'b1);               // counter 0
    tick(); note_valid = 1'b0;               // slot 0
    chk("v03_pend", pending_mask, 4'b1001);
    tick(); tick();                          // slot 2, counter 3
    beat_tick = 1'b1;
    tick(); beat_tick = 1'b0;                // slot 3, FB with beat
    chk("v03_commit", pending_mask, 0);
    chk("all_active", active_mask, 4'b1111);
    req(2'd2, 12'd716, 1'b1);
    tick(); note_valid = 1'b0;               // slot 0
    chk("v0_div", slot_div, 1519);
    chk("v2_late_pend", pending_mask, 4'b0100);
    run_to_slot(2);
    chk("v2_old_div", slot_div, 956);
    run_to_slot(3);
    chk("v3_div", slot_div, 1914);
    chk("v2_needs_beat", pending_mask, 4'b0100);
    beat_tick = 1'b1;                        // counter 0
    tick(); beat_tick = 1'b0;
    run_to_slot(3);
    chk("v2_beat_commit", pending_mask, 0);
    run_to_slot(2);
    chk("v2_new_div", slot_div, 716);

    // Disable with voice 0 staged: commit happens while idle.
    req(2'd0, 12'd318, 1'b0);                // counter 3 (FB)
    tick(); note_valid = 1'b0;               // slot 3
    chk("v0_staged", pending_mask, 4'b0001);
    en = 1'b0;
    tick();
    chk("dis_slot", slot, 0);
    chk("dis_div", slot_div, 0);
    chk("dis_first", slot_first, 0);
    chk("dis_commit", pending_mask, 0);
    tick();
    chk("dis_div2", slot_div, 0);
    en = 1'b1;
    tick();
    chk("reen_slot", slot, 0);
    chk("reen_div", slot_div, 318);
    chk("reen_first", slot_first, 1);

    // Rest note on voice 3 takes effect only from the next frame.
    req(2'd3, 12'd0, 1'b0);                  // counter 1
    tick(); note_valid = 1'b0;
    run_to_slot(3);
    chk("rest_old_div", slot_div, 1914);
    chk("rest_active", active_mask, 4'b0111);
    run_to_slot(3);
    chk("rest_div", slot_div, 0);

`ifdef VOICE_SCHED_MUTE_EN
    mute = 4'b0001;
    #1;
    chk("mute_active", active_mask, 4'b0110);
    run_to_slot(0);
    chk("mute_div", slot_div, 0);
    mute = 4'b0000;
    run_to_slot(0);
    chk("unmute_div", slot_div, 318);
`endif

    // Reset mid-operation drops the staged note.
    req(2'd1, 12'd5, 1'b1);
    tick(); note_valid = 1'b0;
    chk("pre_rst_pend", pending_mask, 4'b0010);
    rst_n = 1'b0;
    tick();
    chk("mrst_pend", pending_mask, 0);
    chk("mrst_active", active_mask, 0);
    chk("mrst_slot_div", slot_div, 0);
    chk("mrst_ready", note_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
